// File: rtl/huffman_packer.sv
// Packs MSB-aligned variable-length codes into W-bit words through a 2W-bit accumulator.
// A flush pads the trailing partial word with zeros and marks it with last_out.
module huffman_packer #(
  parameter int W = 8,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  input  logic [C-1:0] w_in,
  input  logic         en_in,
  output logic         rdy_in,
  input  logic         flush_in,
  output logic [W-1:0] d_out,
  output logic         en_out,
  input  logic         rdy_out,
  output logic         last_out,
  output logic         flush_done,
  output logic         err
);
  localparam int CW = C + 1;
  localparam logic [CW-1:0] WC = CW'(W);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t          state_q;
  logic            live_q;
  logic [2*W-1:0]  acc_q, acc_d, app;
  logic [CW-1:0]   cnt_q, cnt_d, base;
  logic [W-1:0]    d_out_q, mask;
  logic            en_out_q, last_q, err_q;
  logic            xfer, legal, free, drain, pad, flush_req, last_d;

  // live_q keeps rdy_in low during reset and lets it rise on the first edge after release
  assign rdy_in    = live_q && (state_q == RUN) && (cnt_q <= WC);
  assign xfer      = en_in && rdy_in;
  assign legal     = (w_in != '0) && ({1'b0, w_in} <= WC);
  assign free      = !en_out_q || rdy_out;
  assign drain     = (cnt_q >= WC) && free;
  assign flush_req = live_q && (state_q == RUN) && flush_in && !en_in;
  assign pad       = (state_q == FLUSH) && (cnt_q != '0) && (cnt_q < WC) && free;
  assign last_d    = pad || ((cnt_q == WC) && ((state_q == FLUSH) || flush_req));

  // Bits below the code length are zeroed so padding and later appends stay clean
  assign mask = ~({W{1'b1}} >> w_in);
  assign app  = {d_in & mask, {W{1'b0}}} >> base;

  always_comb begin
    base  = drain ? (cnt_q - WC) : cnt_q;
    acc_d = drain ? (acc_q << W) : acc_q;
    cnt_d = base;
    if (xfer && legal) begin
      acc_d = acc_d | app;
      cnt_d = base + CW'(w_in);
    end
    if (pad) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      live_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      d_out_q  <= '0;
      en_out_q <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      if (xfer && !legal) err_q <= 1'b1;
      if (drain || pad) begin
        d_out_q  <= acc_q[2*W-1:W];
        en_out_q <= 1'b1;
        last_q   <= last_d;
      end else if (rdy_out) begin
        en_out_q <= 1'b0;
        last_q   <= 1'b0;
      end
      case (state_q)
        RUN:     if (flush_req) state_q <= FLUSH;
        FLUSH:   if ((cnt_q == '0) && free) state_q <= DONE;
        DONE:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign d_out      = d_out_q;
  assign en_out     = en_out_q;
  assign last_out   = last_q;
  assign flush_done = (state_q == DONE);
  assign err        = err_q;
endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer (W=8, C=4): accepted words are captured on the
// falling edge and compared against hand-computed sequences.
module tb_huffman_packer;
  logic       clk, rst;
  logic [7:0] d_in;
  logic [3:0] w_in;
  logic       en_in, rdy_in, flush_in;
  logic [7:0] d_out;
  logic       en_out, rdy_out, last_out, flush_done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  logic [7:0] wq[$];
  bit         lq[$];
  int         cq[$];

  huffman_packer #(.W(8), .C(4)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .w_in(w_in), .en_in(en_in), .rdy_in(rdy_in),
    .flush_in(flush_in), .d_out(d_out), .en_out(en_out), .rdy_out(rdy_out),
    .last_out(last_out), .flush_done(flush_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && en_out && rdy_out) begin
      wq.push_back(d_out);
      lq.push_back(last_out);
      cq.push_back(cyc);
    end
    if (!rst && flush_done) fd_cnt = fd_cnt + 1;
  end

  task automatic clear_q();
    wq.delete(); lq.delete(); cq.delete();
    fd_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] w);
    int g = 0;
    en_in = 1'b1; d_in = d; w_in = w;
    while (!rdy_in && g < 100) begin @(posedge clk); #1; g++; end
    if (!rdy_in) begin
      checks++; errors++;
      $display("FAIL send_timeout rdy_in=%b required 1", rdy_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en_in = 1'b0; flush_in = 1'b0; d_in = 8'h5A;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flush();
    en_in = 1'b0; flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy_out = 1'b1; en_in = 1'b0; flush_in = 1'b0; d_in = '0; w_in = '0;
    #1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({d_out, en_out, last_out, flush_done, err, rdy_in} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs got d=%h en=%b last=%b fd=%b err=%b rdy=%b required all 0",
               d_out, en_out, last_out, flush_done, err, rdy_in);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_in !== 1'b0) begin errors++; $display("FAIL reset_rdy_early got %b required 0", rdy_in); end
    @(posedge clk); #1;
    checks++;
    if (rdy_in !== 1'b1) begin errors++; $display("FAIL reset_rdy_rise got %b required 1", rdy_in); end
    clear_q();
  endtask

  task automatic test_basic();
    clear_q();
    send(8'h00, 2); send(8'h7F, 2); send(8'h3F, 2); send(8'h40, 2);
    idle(4);
    checks++;
    if (wq.size() !== 1) begin errors++; $display("FAIL basic_count got %0d required 1", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== 8'h11) begin errors++; $display("FAIL basic_word got %h required 11", wq[0]); end
      checks++;
      if (lq[0] !== 1'b0) begin errors++; $display("FAIL basic_last got %b required 0", lq[0]); end
    end
  endtask

  task automatic test_three_bit();
    logic [7:0] exp [3];
    exp[0] = 8'h96; exp[1] = 8'h59; exp[2] = 8'h65;
    clear_q();
    for (int i = 0; i < 4; i++) begin send(8'h9F, 3); send(8'hBF, 3); end
    idle(6);
    checks++;
    if (wq.size() !== 3) begin errors++; $display("FAIL three_count got %0d required 3", wq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (wq[i] !== exp[i]) begin errors++; $display("FAIL three_word%0d got %h required %h", i, wq[i], exp[i]); end
    end
  endtask

  task automatic test_mixed();
    clear_q();
    send(8'h00, 2); send(8'hDF, 4); send(8'h3F, 2); send(8'hFC, 8);
    idle(4);
    checks++;
    if (wq.size() !== 2) begin errors++; $display("FAIL mixed_count got %0d required 2", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== 8'h34) begin errors++; $display("FAIL mixed_word0 got %h required 34", wq[0]); end
      checks++;
      if (wq[1] !== 8'hFC) begin errors++; $display("FAIL mixed_word1 got %h required fc", wq[1]); end
      checks++;
      if (cq[1] - cq[0] !== 1) begin errors++; $display("FAIL mixed_spacing got %0d required 1", cq[1] - cq[0]); end
    end
  endtask

  task automatic test_flush();
    clear_q();
    send(8'hF3, 6); flush(); idle(6);
    checks++;
    if (wq.size() !== 1) begin errors++; $display("FAIL flush_count got %0d required 1", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== 8'hF0 || lq[0] !== 1'b1) begin
        errors++; $display("FAIL flush_word got %h last %b required f0 last 1", wq[0], lq[0]);
      end
    end
    checks++;
    if (fd_cnt !== 1) begin errors++; $display("FAIL flush_done_pulse got %0d required 1", fd_cnt); end

    clear_q();
    flush(); idle(5);
    checks++;
    if (wq.size() !== 0 || fd_cnt !== 1) begin
      errors++; $display("FAIL flush_empty got words %0d pulses %0d required 0 and 1", wq.size(), fd_cnt);
    end

    clear_q();
    send(8'hFF, 8); flush(); idle(6);
    checks++;
    if (wq.size() !== 1) begin errors++; $display("FAIL flush_full_count got %0d required 1", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== 8'hFF || lq[0] !== 1'b1) begin
        errors++; $display("FAIL flush_full_word got %h last %b required ff last 1", wq[0], lq[0]);
      end
    end
    checks++;
    if (fd_cnt !== 1) begin errors++; $display("FAIL flush_full_pulse got %0d required 1", fd_cnt); end

    clear_q();
    flush_in = 1'b1;
    send(8'hAF, 4); send(8'h5F, 4);
    idle(5);
    checks++;
    if (fd_cnt !== 0 || wq.size() !== 1) begin
      errors++; $display("FAIL flush_with_en got pulses %0d words %0d required 0 and 1", fd_cnt, wq.size());
    end else begin
      checks++;
      if (wq[0] !== 8'hA5 || lq[0] !== 1'b0) begin
        errors++; $display("FAIL flush_with_en_word got %h last %b required a5 last 0", wq[0], lq[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ew[$];
    bit         eb[$];
    logic [4:0] v;
    logic [7:0] w8;
    logic [7:0] hold;
    bit         sawlow = 0;
    int         bad = 0;
    clear_q();
    for (int k = 0; k < 12; k++) begin
      v = 5'((k * 7 + 3) % 32);
      for (int b = 4; b >= 0; b--) eb.push_back(v[b]);
    end
    while (eb.size() % 8 != 0) eb.push_back(1'b0);
    for (int i = 0; i < eb.size(); i += 8) begin
      for (int j = 0; j < 8; j++) w8[7-j] = eb[i+j];
      ew.push_back(w8);
    end
    fork
      begin
        for (int k = 0; k < 12; k++) send({5'((k * 7 + 3) % 32), 3'b101}, 5);
        en_in = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 rdy_out = 1'b0;
        @(posedge clk); #1;
        hold = d_out;
        if (!rdy_in) sawlow = 1;
        repeat (5) begin
          @(posedge clk); #1;
          if (en_out !== 1'b1 || d_out !== hold) bad++;
          if (!rdy_in) sawlow = 1;
        end
        rdy_out = 1'b1;
      end
    join
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles required 0", bad); end
    checks++;
    if (!sawlow) begin errors++; $display("FAIL bp_rdy_in_fall got no low cycle required low while stalled"); end
    flush(); idle(8);
    checks++;
    if (wq.size() !== ew.size()) begin
      errors++; $display("FAIL bp_count got %0d required %0d", wq.size(), ew.size());
    end else for (int i = 0; i < ew.size(); i++) begin
      checks++;
      if (wq[i] !== ew[i] || lq[i] !== (i == ew.size() - 1)) begin
        errors++; $display("FAIL bp_word%0d got %h last %b required %h last %b",
                           i, wq[i], lq[i], ew[i], (i == ew.size() - 1));
      end
    end
  endtask

  task automatic test_err_reset();
    clear_q();
    send(8'hFF, 0); idle(2);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b required 1", err); end
    send(8'hAF, 4); send(8'h5F, 4); idle(4);
    checks++;
    if (wq.size() !== 1) begin errors++; $display("FAIL err_stream_count got %0d required 1", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== 8'hA5) begin errors++; $display("FAIL err_stream_word got %h required a5", wq[0]); end
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b required 1", err); end

    clear_q();
    send(8'hE0, 3);
    en_in = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({d_out, en_out, last_out, flush_done, err, rdy_in} !== 13'b0) begin
      errors++;
      $display("FAIL midreset_outputs got d=%h en=%b last=%b fd=%b err=%b rdy=%b required all 0",
               d_out, en_out, last_out, flush_done, err, rdy_in);
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy_in !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL midreset_release got rdy=%b err=%b required 1 and 0", rdy_in, err);
    end
    idle(4);
    checks++;
    if (wq.size() !== 0) begin errors++; $display("FAIL midreset_stale got %0d words required 0", wq.size()); end
    send(8'h3C, 8); idle(3);
    checks++;
    if (wq.size() !== 1) begin errors++; $display("FAIL postreset_count got %0d required 1", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== 8'h3C) begin errors++; $display("FAIL postreset_word got %h required 3c", wq[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_three_bit();
    test_mixed();
    test_flush();
    test_backpressure();
    test_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
